wb_stage: RTL
=============

Name: wb_stage

Overview:
- Writeback stage directly upstream of the integer register file; the only producer of the file's A3/WE3/WD3 write port.
- Accepts retiring instructions from the MEM stage over a valid/ready handshake.
- Selects the result source: ALU, load data, or PC+4.
- Waits a variable number of cycles for load responses, sign/zero-extends load data, and issues a single-cycle write pulse per instruction.

Parameters:
- XLEN, 32, datapath width
- NUM_REGS, 8, highest implemented register index; registers are 1..NUM_REGS and x0 is hardwired zero

Ports:
- CLK  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high reset
- mem_valid  in  1  MEM stage presents an instruction
- mem_ready  out  1  stage can accept an instruction this cycle
- mem_rd  in  5  destination register
- mem_reg_write  in  1  instruction writes rd
- mem_result_src  in  2  00 ALU, 01 LOAD, 10 PC+4, 11 reserved
- mem_funct3  in  3  load type
- mem_alu_result  in  XLEN  ALU result / load address
- mem_pc_plus4  in  XLEN  link value
- dmem_rvalid  in  1  load data valid, one-cycle pulse
- dmem_rdata  in  XLEN  raw aligned word from data memory
- A3  out  5  register-file write address
- WE3  out  1  register-file write enable
- WD3  out  XLEN  register-file write data
- wb_err  out  1  one-cycle pulse: illegal rd or illegal load type

Behaviour:
- Reset values: A3=0, WE3=0, WD3=0, wb_err=0, state=IDLE, mem_ready=1.
- State IDLE:
  - mem_ready=1.
  - Accept occurs when mem_valid && mem_ready.
  - Non-load accept (src 00/10): A3, WD3 and WE3 are registered on the same edge and driven the following cycle. State stays IDLE; back-to-back throughput is 1 instruction/cycle.
  - Load accept (src 01): capture rd, reg_write, funct3 and alu_result[1:0]; go to WAIT_MEM. WE3=0 next cycle.
  - src 11: instruction is consumed, no write, wb_err pulses next cycle.
- State WAIT_MEM:
  - mem_ready=0.
  - On dmem_rvalid: extend the data, register the outputs (WE3 per the rules below), return to IDLE.
  - No timeout; the stage holds indefinitely.
  - dmem_rvalid in IDLE is ignored.
- Output timing:
  - Outputs change only on posedge and are held a full cycle, so the register file's negedge write samples stable values.
  - WE3 is high for exactly one cycle per write; A3/WD3 hold their last values when WE3=0.
- Write suppression (WE3=0):
  - mem_reg_write=0;
  - rd==0 (silent);
  - rd>NUM_REGS: wb_err pulses;
  - illegal load funct3 (011, 110, 111): wb_err pulses.
- Load extension, with off = captured alu_result[1:0]:
  - LB (000): byte off, sign-extended.
  - LBU (100): byte off, zero-extended.
  - LH (001): halfword off[1], sign-extended.
  - LHU (101): halfword off[1], zero-extended.
  - LH/LHU: off[0] is ignored.
  - LW (010): full word; off is ignored.
- Reset asserted mid-WAIT_MEM: the pending load is discarded, no write occurs, state returns to IDLE with reset values.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- When defined:
  - Adds output retire_cnt (64 bits), reset to 0.
  - Increments by 1 on every cycle the stage registers a completed instruction (non-load accept, load completion, or a reserved-src accept), whether or not WE3 is asserted.
  - Wraps modulo 2^64.
- When undefined: the port and counter are absent, with no other behavioural change.

Decomposition:
- Package wb_pkg:
  - result-src encodings SRC_ALU/SRC_LOAD/SRC_PC4;
  - load funct3 constants F3_LB/F3_LH/F3_LW/F3_LBU/F3_LHU;
  - state enum {IDLE, WAIT_MEM};
  - XLEN default.
- Sub-module load_extend: combinational; inputs funct3, off[1:0], rdata; outputs data and illegal flag. Reused by any future misaligned-load unit.

Test Plan:
- Reset, then ALU op (rd=5, alu=0x1234_5678, reg_write=1) -> next cycle WE3=1, A3=5, WD3=0x12345678; following cycle WE3=0.
- Load LB, off=3, dmem_rdata=0x80AA_BBCC, rvalid after 4 cycles -> mem_ready=0 for 4 cycles; then WE3=1, WD3=0xFFFF_FF80. Same load as LBU -> WD3=0x0000_0080.
- LH, off=2, rdata=0x8001_0000 -> WD3=0xFFFF_8001. LW, off=1, rdata=0xDEAD_BEEF -> WD3=0xDEADBEEF.
- rd=0 with reg_write=1 -> WE3=0, wb_err=0. rd=9 -> WE3=0, wb_err=1 for one cycle. Load funct3=011 -> WE3=0, wb_err=1.
- Three back-to-back ALU ops to rd=1,2,3 -> three consecutive WE3 pulses with matching A3/WD3; mem_ready stays 1.
- Assert reset while in WAIT_MEM, then pulse dmem_rvalid -> no WE3; mem_ready=1 after reset. With WB_RETIRE_CNT_EN, retire_cnt=0 after reset and 3 after the back-to-back test.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared encodings for the writeback stage.
//   - result-source encodings (ALU / LOAD / PC+4; 2'b11 is reserved)
//   - load funct3 encodings
//   - writeback state enum
//   - default datapath width
package wb_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [1:0] SRC_ALU  = 2'b00;
    localparam logic [1:0] SRC_LOAD = 2'b01;
    localparam logic [1:0] SRC_PC4  = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_e;

endpackage

// File: rtl/load_extend.sv
// load_extend: combinational load-data lane select and sign/zero extension.
// Ports:
//   funct3  in   load type (LB/LH/LW/LBU/LHU)
//   off     in   byte offset within the word (address bits [1:0])
//   rdata   in   raw aligned word from data memory
//   data    out  extended result
//   illegal out  funct3 is not a defined load type (data is then 0)
// Halfword loads use off[1] only; word loads ignore off entirely.
module load_extend
    import wb_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data,
    output logic            illegal
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (off)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data    = '0;
        illegal = 1'b0;
        case (funct3)
            F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
            F3_LW:   data = rdata;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback stage feeding the integer register file write port.
// Accepts retiring instructions from MEM (valid/ready), selects ALU / load /
// PC+4 result, waits any number of cycles for a load response, and emits a
// single-cycle registered write (A3/WE3/WD3). wb_err pulses for an
// out-of-range rd, an illegal load funct3 or the reserved result source.
// Ports:
//   CLK, reset           clock, async active-high reset
//   mem_*                instruction from MEM stage; mem_ready back-pressure
//   dmem_rvalid/rdata    load response (one-cycle pulse)
//   A3/WE3/WD3           register-file write port (registered)
//   wb_err               one-cycle error pulse (registered)
//   retire_cnt           64-bit completed-instruction count, present only
//                        when WB_RETIRE_CNT_EN is defined
module wb_stage
    import wb_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NUM_REGS = 8
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [4:0]      mem_rd,
    input  logic            mem_reg_write,
    input  logic [1:0]      mem_result_src,
    input  logic [2:0]      mem_funct3,
    input  logic [XLEN-1:0] mem_alu_result,
    input  logic [XLEN-1:0] mem_pc_plus4,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [4:0]      A3,
    output logic            WE3,
    output logic [XLEN-1:0] WD3,
    output logic            wb_err
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0]     retire_cnt
`endif
);

    wb_state_e       state_q, state_d;
    logic [4:0]      a3_q, a3_d;
    logic            we3_q, we3_d;
    logic [XLEN-1:0] wd3_q, wd3_d;
    logic            err_q, err_d;
    // Load held while waiting for the memory response
    logic [4:0]      pend_rd_q, pend_rd_d;
    logic            pend_we_q, pend_we_d;
    logic [2:0]      pend_f3_q, pend_f3_d;
    logic [1:0]      pend_off_q, pend_off_d;
    logic            retire;

    logic [XLEN-1:0] ld_data;
    logic            ld_illegal;

    load_extend #(.XLEN(XLEN)) u_ext (
        .funct3  (pend_f3_q),
        .off     (pend_off_q),
        .rdata   (dmem_rdata),
        .data    (ld_data),
        .illegal (ld_illegal)
    );

    function automatic logic rd_oob(input logic [4:0] rd);
        return 32'(rd) > NUM_REGS;
    endfunction

    assign mem_ready = (state_q == IDLE);

    always_comb begin
        state_d    = state_q;
        a3_d       = a3_q;
        wd3_d      = wd3_q;
        we3_d      = 1'b0;
        err_d      = 1'b0;
        pend_rd_d  = pend_rd_q;
        pend_we_d  = pend_we_q;
        pend_f3_d  = pend_f3_q;
        pend_off_d = pend_off_q;
        retire     = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_valid) begin
                    case (mem_result_src)
                        SRC_LOAD: begin
                            pend_rd_d  = mem_rd;
                            pend_we_d  = mem_reg_write;
                            pend_f3_d  = mem_funct3;
                            pend_off_d = mem_alu_result[1:0];
                            state_d    = WAIT_MEM;
                        end
                        SRC_ALU, SRC_PC4: begin
                            retire = 1'b1;
                            // rd only matters when the instruction writes it
                            if (mem_reg_write && mem_rd != 5'd0) begin
                                if (rd_oob(mem_rd)) begin
                                    err_d = 1'b1;
                                end else begin
                                    we3_d = 1'b1;
                                    a3_d  = mem_rd;
                                    wd3_d = (mem_result_src == SRC_PC4) ? mem_pc_plus4
                                                                        : mem_alu_result;
                                end
                            end
                        end
                        default: begin
                            retire = 1'b1;
                            err_d  = 1'b1;
                        end
                    endcase
                end
            end
            WAIT_MEM: begin
                if (dmem_rvalid) begin
                    retire  = 1'b1;
                    state_d = IDLE;
                    // an undefined load type is flagged even if rd is unused
                    if (ld_illegal) begin
                        err_d = 1'b1;
                    end else if (pend_we_q && pend_rd_q != 5'd0) begin
                        if (rd_oob(pend_rd_q)) begin
                            err_d = 1'b1;
                        end else begin
                            we3_d = 1'b1;
                            a3_d  = pend_rd_q;
                            wd3_d = ld_data;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            a3_q       <= '0;
            we3_q      <= 1'b0;
            wd3_q      <= '0;
            err_q      <= 1'b0;
            pend_rd_q  <= '0;
            pend_we_q  <= 1'b0;
            pend_f3_q  <= '0;
            pend_off_q <= '0;
        end else begin
            state_q    <= state_d;
            a3_q       <= a3_d;
            we3_q      <= we3_d;
            wd3_q      <= wd3_d;
            err_q      <= err_d;
            pend_rd_q  <= pend_rd_d;
            pend_we_q  <= pend_we_d;
            pend_f3_q  <= pend_f3_d;
            pend_off_q <= pend_off_d;
        end
    end

    assign A3     = a3_q;
    assign WE3    = we3_q;
    assign WD3    = wd3_q;
    assign wb_err = err_q;

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + (retire ? 64'd1 : 64'd0);
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign retire_cnt = cnt_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

endmodule
